// File: rtl/overlay_window_ctrl.sv
// Overlay window controller: tracks the active-pixel position from the video
// timing strobes and raises a registered overlay select inside a rectangle.
// It also emits window-relative coordinates. The window config is double-buffered
// and swaps in only on a vsync rising edge, so a frame never tears.
module overlay_window_ctrl #(
  parameter int CW       = 12,
  parameter int H_ACTIVE = 1920,
  parameter int V_ACTIVE = 1080
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          de_in,
  input  logic          vsync_in,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic          cfg_en,
  input  logic [CW-1:0] cfg_x0,
  input  logic [CW-1:0] cfg_y0,
  input  logic [CW-1:0] cfg_w,
  input  logic [CW-1:0] cfg_h,
  output logic          overlay_enable,
  output logic [CW-1:0] ovl_x,
  output logic [CW-1:0] ovl_y,
  output logic          frame_start
);

  localparam logic [CW-1:0] X_MAX = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0] Y_MAX = CW'(V_ACTIVE - 1);

  typedef enum logic {SYNC_WAIT, RUN} state_t;

  state_t        r_state, w_state_nxt;
  logic          r_de, r_vs;
  logic [CW-1:0] r_x, r_y;
  logic          r_pend_v, r_pend_en, r_act_en;
  logic [CW-1:0] r_pend_x0, r_pend_y0, r_pend_w, r_pend_h;
  logic [CW-1:0] r_act_x0, r_act_y0, r_act_w, r_act_h;
  logic          r_ovl_en, r_fs;
  logic [CW-1:0] r_ovl_x, r_ovl_y;

  logic          w_vs_rise, w_de_fall, w_cfg_hs, w_hit, w_run;
  logic [CW:0]   w_x_end, w_y_end;

  assign w_vs_rise = vsync_in & ~r_vs;
  assign w_de_fall = ~de_in & r_de;
  assign w_cfg_hs  = cfg_valid & ~r_pend_v;
  assign w_run     = (r_state == RUN);

  // Window extents one bit wider than the coordinates so x0+w never wraps;
  // a window reaching past the active area simply clips.
  assign w_x_end = {1'b0, r_act_x0} + {1'b0, r_act_w};
  assign w_y_end = {1'b0, r_act_y0} + {1'b0, r_act_h};
  assign w_hit   = r_act_en & de_in & (|r_act_w) & (|r_act_h)
                 & ({1'b0, r_x} >= {1'b0, r_act_x0}) & ({1'b0, r_x} < w_x_end)
                 & ({1'b0, r_y} >= {1'b0, r_act_y0}) & ({1'b0, r_y} < w_y_end);

  // State register for the sync-acquire FSM
  always_ff @(posedge clk) begin
    if (reset) r_state <= SYNC_WAIT;
    else       r_state <= w_state_nxt;
  end

  // Next state: leave SYNC_WAIT on the first frame boundary, then run until reset
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      SYNC_WAIT: if (w_vs_rise) w_state_nxt = RUN;
      RUN:       w_state_nxt = RUN;
      default:   w_state_nxt = SYNC_WAIT;
    endcase
  end

  // Delayed strobes for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      r_de <= 1'b0;
      r_vs <= 1'b0;
    end else begin
      r_de <= de_in;
      r_vs <= vsync_in;
    end
  end

  // Active-pixel position: x counts pixels in the line, y counts lines, both saturate
  always_ff @(posedge clk) begin
    if (reset || w_vs_rise) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_de_fall) begin
      r_x <= '0;
      if (r_y != Y_MAX) r_y <= r_y + 1'b1;
    end else if (de_in && (r_x != X_MAX)) begin
      r_x <= r_x + 1'b1;
    end
  end

  // Config double buffer: the handshake fills the pending slot, and the frame boundary commits it
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend_v  <= 1'b0;
      r_pend_en <= 1'b0;
      r_pend_x0 <= '0;
      r_pend_y0 <= '0;
      r_pend_w  <= '0;
      r_pend_h  <= '0;
      r_act_en  <= 1'b0;
      r_act_x0  <= '0;
      r_act_y0  <= '0;
      r_act_w   <= '0;
      r_act_h   <= '0;
    end else begin
      if (w_vs_rise && r_pend_v) begin
        r_act_en <= r_pend_en;
        r_act_x0 <= r_pend_x0;
        r_act_y0 <= r_pend_y0;
        r_act_w  <= r_pend_w;
        r_act_h  <= r_pend_h;
        r_pend_v <= 1'b0;
      end
      // A write is only taken when the slot was empty, so it never collides with a commit
      if (w_cfg_hs) begin
        r_pend_en <= cfg_en;
        r_pend_x0 <= cfg_x0;
        r_pend_y0 <= cfg_y0;
        r_pend_w  <= cfg_w;
        r_pend_h  <= cfg_h;
        r_pend_v  <= 1'b1;
      end
    end
  end

  // Registered outputs: select and relative coordinates one cycle after the de sample
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovl_en <= 1'b0;
      r_ovl_x  <= '0;
      r_ovl_y  <= '0;
      r_fs     <= 1'b0;
    end else begin
      r_ovl_en <= w_hit & w_run;
      if (w_hit && w_run) begin
        r_ovl_x <= r_x - r_act_x0;
        r_ovl_y <= r_y - r_act_y0;
      end
      r_fs <= w_vs_rise;
    end
  end

  assign cfg_ready      = ~r_pend_v;
  assign overlay_enable = r_ovl_en;
  assign ovl_x          = r_ovl_x;
  assign ovl_y          = r_ovl_y;
  assign frame_start    = r_fs;

endmodule

// File: tb/tb_overlay_window_ctrl.sv
// Bench for overlay_window_ctrl: drives 64x16 frames and checks every cycle
// against a pixel-coordinate model of the window rules. Literal per-frame
// expectations pin the model.
module tb_overlay_window_ctrl;

  localparam int CW = 12;
  localparam int LW = 64;   // active pixels per line
  localparam int LT = 68;   // total cycles per line
  localparam int NL = 16;   // lines per frame

  typedef struct packed {
    bit en;
    int x0;
    int y0;
    int w;
    int h;
  } win_t;

  logic          clk = 1'b0;
  logic          reset, de_in, vsync_in, cfg_valid, cfg_en;
  logic [CW-1:0] cfg_x0, cfg_y0, cfg_w, cfg_h;
  logic          cfg_ready, overlay_enable, frame_start;
  logic [CW-1:0] ovl_x, ovl_y;

  overlay_window_ctrl #(.CW(CW), .H_ACTIVE(1920), .V_ACTIVE(1080)) dut (
    .clk(clk), .reset(reset), .de_in(de_in), .vsync_in(vsync_in),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_en(cfg_en),
    .cfg_x0(cfg_x0), .cfg_y0(cfg_y0), .cfg_w(cfg_w), .cfg_h(cfg_h),
    .overlay_enable(overlay_enable), .ovl_x(ovl_x), .ovl_y(ovl_y),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit chk_on = 1'b0;

  // Generator position of the pixel being driven
  int g_col = 0;
  int g_line = 0;

  // Model state
  win_t m_act, m_pend;
  bit   m_pv, m_run, m_prev_vs;
  bit   exp_en, exp_fs, exp_rdy;
  int   exp_ox, exp_oy;

  // Running statistics gathered by the compare process
  int tot_en = 0;
  int tot_fs = 0;
  int last_ox = 0;
  int last_oy = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model of the rules, stepped with the inputs sampled at each clock edge
  task automatic model_update();
    bit vs_rise, hit, hs;
    if (reset) begin
      m_act = '0; m_pend = '0; m_pv = 0; m_run = 0; m_prev_vs = 0;
      exp_en = 0; exp_fs = 0; exp_ox = 0; exp_oy = 0; exp_rdy = 1;
      return;
    end
    vs_rise   = vsync_in && !m_prev_vs;
    m_prev_vs = vsync_in;
    hit = de_in && m_act.en && (m_act.w > 0) && (m_act.h > 0)
       && (g_col >= m_act.x0) && (g_col < m_act.x0 + m_act.w)
       && (g_line >= m_act.y0) && (g_line < m_act.y0 + m_act.h);
    exp_en = m_run && hit;
    if (exp_en) begin
      exp_ox = g_col - m_act.x0;
      exp_oy = g_line - m_act.y0;
    end
    exp_fs = vs_rise;
    hs = cfg_valid && !m_pv;
    if (vs_rise) begin
      if (m_pv) begin
        m_act = m_pend;
        m_pv  = 0;
      end
      m_run = 1;
    end
    if (hs) begin
      m_pend = '{cfg_en, int'(cfg_x0), int'(cfg_y0), int'(cfg_w), int'(cfg_h)};
      m_pv   = 1;
    end
    exp_rdy = !m_pv;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_update();
  endtask

  task automatic set_cfg(input win_t w);
    cfg_en = w.en;
    cfg_x0 = CW'(w.x0);
    cfg_y0 = CW'(w.y0);
    cfg_w  = CW'(w.w);
    cfg_h  = CW'(w.h);
  endtask

  task automatic write_cfg(input win_t w);
    set_cfg(w);
    de_in = 0; vsync_in = 0; cfg_valid = 1;
    step();
    cfg_valid = 0;
    step();
  endtask

  // One frame: vsync pulse, blanking, NL lines; optional mid-frame write,
  // write on the vsync edge cycle, or reset at a given pixel
  task automatic frame(input int wr_line, input bit vs_write, input win_t wc,
                       input int rst_line, input int rst_col);
    de_in = 0;
    set_cfg(wc);
    for (int i = 0; i < 2; i++) begin
      vsync_in  = 1;
      cfg_valid = vs_write && (i == 0);
      step();
    end
    cfg_valid = 0;
    vsync_in  = 0;
    for (int i = 0; i < 2; i++) step();
    for (int l = 0; l < NL; l++) begin
      for (int c = 0; c < LT; c++) begin
        g_line    = l;
        g_col     = c;
        de_in     = (c < LW);
        cfg_valid = (l == wr_line) && (c == 0);
        reset     = (l == rst_line) && (c == rst_col);
        step();
        cfg_valid = 0;
        reset     = 0;
      end
    end
    de_in = 0;
  endtask

  task automatic plain_frame();
    frame(-1, 1'b0, '0, -1, -1);
  endtask

  // Compare process: every cycle, DUT outputs against the model
  always @(negedge clk) begin
    if (chk_on) begin
      chk("overlay_enable", overlay_enable, exp_en);
      chk("ovl_x", ovl_x, exp_ox);
      chk("ovl_y", ovl_y, exp_oy);
      chk("frame_start", frame_start, exp_fs);
      chk("cfg_ready", cfg_ready, exp_rdy);
      if (overlay_enable === 1'b1) begin
        tot_en++;
        last_ox = int'(ovl_x);
        last_oy = int'(ovl_y);
      end
      if (frame_start === 1'b1) tot_fs++;
    end
  end

  initial begin
    win_t wa, wb, wc, wz;
    int   base, fbase;
    wa = '{1'b1, 10, 5, 4, 2};
    wb = '{1'b1, 20, 2, 3, 3};
    wc = '{1'b1, 0, 0, 2, 1};
    wz = '0;
    reset = 1; de_in = 0; vsync_in = 0; cfg_valid = 0;
    set_cfg(wz);
    step();
    chk_on = 1;
    step();
    reset = 0;
    chk("rst_enable", overlay_enable, 0);
    chk("rst_ready", cfg_ready, 1);
    chk("rst_frame_start", frame_start, 0);
    chk("rst_ovl_x", ovl_x, 0);

    // 1: basic window, nothing before the first vsync
    write_cfg(wa);
    chk("t1_ready_after_write", cfg_ready, 0);
    base = tot_en;
    for (int l = 0; l < 8; l++)
      for (int c = 0; c < LT; c++) begin
        g_line = l; g_col = c; de_in = (c < LW);
        step();
      end
    de_in = 0;
    chk("t1_pre_vsync_count", tot_en - base, 0);
    base = tot_en; fbase = tot_fs;
    plain_frame();
    chk("t1_count", tot_en - base, 8);
    chk("t1_last_ox", last_ox, 3);
    chk("t1_last_oy", last_oy, 1);
    chk("t1_fs_count", tot_fs - fbase, 1);
    chk("t1_ready", cfg_ready, 1);

    // 2: mid-frame write applies from the next frame
    base = tot_en;
    frame(3, 1'b0, wb, -1, -1);
    chk("t2_same_frame_count", tot_en - base, 8);
    chk("t2_ready_pending", cfg_ready, 0);
    base = tot_en;
    plain_frame();
    chk("t2_next_count", tot_en - base, 9);
    chk("t2_last_ox", last_ox, 2);
    chk("t2_last_oy", last_oy, 2);
    chk("t2_ready", cfg_ready, 1);

    // 3: write coinciding with the vsync edge lands one frame later
    base = tot_en;
    frame(-1, 1'b1, wc, -1, -1);
    chk("t3_same_frame_count", tot_en - base, 9);
    chk("t3_ready_pending", cfg_ready, 0);
    base = tot_en;
    plain_frame();
    chk("t3_next_count", tot_en - base, 2);
    chk("t3_last_ox", last_ox, 1);
    chk("t3_last_oy", last_oy, 0);

    // 4: disabled, empty and right-clipped windows
    write_cfg('{1'b0, 10, 5, 4, 2});
    base = tot_en;
    plain_frame();
    chk("t4_en0_count", tot_en - base, 0);
    write_cfg('{1'b1, 10, 5, 0, 2});
    base = tot_en;
    plain_frame();
    chk("t4_w0_count", tot_en - base, 0);
    write_cfg('{1'b1, 60, 0, 10, 2});
    base = tot_en;
    plain_frame();
    chk("t4_clip_count", tot_en - base, 8);
    chk("t4_clip_last_ox", last_ox, 3);
    chk("t4_clip_last_oy", last_oy, 1);

    // 5: reset inside the window
    write_cfg(wa);
    plain_frame();
    base = tot_en;
    frame(-1, 1'b0, '0, 5, 11);
    chk("t5_reset_frame_count", tot_en - base, 1);
    chk("t5_enable_low", overlay_enable, 0);
    chk("t5_ready_after_reset", cfg_ready, 1);
    base = tot_en;
    plain_frame();
    chk("t5_cleared_cfg_count", tot_en - base, 0);
    write_cfg(wa);
    base = tot_en;
    plain_frame();
    chk("t5_recover_count", tot_en - base, 8);

    // 6: x0 near the top of the coordinate range must not wrap
    write_cfg('{1'b1, (1 << CW) - 2, 0, 4, 16});
    base = tot_en;
    plain_frame();
    chk("t6_nowrap_count", tot_en - base, 0);

    step();
    chk_on = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
